// File: rtl/store_unit_pkg.sv
// Shared encodings for the store unit: funct3 store sizes, error codes, FSM states.
package store_unit_pkg;

    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_ERR   = 2'b10
    } state_e;

endpackage

// File: rtl/store_align.sv
// Lane steering for byte/half/word stores: byte enables, replicated write data,
// misalignment and illegal-funct3 detection.
module store_align
    import store_unit_pkg::*;
(
    input  logic [1:0]     addr_lo_i,
    input  logic [DW-1:0]  data_i,
    input  logic [2:0]     f3_i,
    output logic [BEW-1:0] be_c_o,
    output logic [DW-1:0]  wdata_c_o,
    output logic           misalign_c_o,
    output logic           illegal_c_o
);

    // Decode store size into lane enables and replicated data.
    always_comb begin
        be_c_o       = '0;
        wdata_c_o    = data_i;
        misalign_c_o = 1'b0;
        illegal_c_o  = 1'b0;
        case (f3_i)
            F3_SB: begin
                be_c_o    = BEW'(4'b0001 << addr_lo_i);
                wdata_c_o = {4{data_i[7:0]}};
            end
            F3_SH: begin
                be_c_o       = BEW'(4'b0011 << addr_lo_i);
                wdata_c_o    = {2{data_i[15:0]}};
                misalign_c_o = addr_lo_i[0];
            end
            F3_SW: begin
                be_c_o       = 4'b1111;
                misalign_c_o = (addr_lo_i != 2'b00);
            end
            default: begin
                illegal_c_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store at a time, issues a word-aligned write to data
// memory and reports completion, rejection or ack timeout as one-cycle pulses.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned AW      = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           st_valid_i,
    output logic           st_ready_o,
    input  logic [AW-1:0]  st_addr_i,
    input  logic [DW-1:0]  st_data_i,
    input  logic [2:0]     st_f3_i,
    output logic           mem_req_o,
    output logic [AW-1:0]  mem_addr_o,
    output logic [DW-1:0]  mem_wdata_o,
    output logic [BEW-1:0] mem_be_o,
    input  logic           mem_ack_i,
    output logic           st_done_o,
    output logic           st_err_o,
    output logic [1:0]     err_code_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           st_ready_q, st_ready_d;
    logic           mem_req_q, mem_req_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
    logic [BEW-1:0] mem_be_q, mem_be_d;
    logic           st_done_q, st_done_d;
    logic           st_err_q, st_err_d;
    err_code_e      err_code_q, err_code_d;

    logic [BEW-1:0] be_c;
    logic [DW-1:0]  wdata_c;
    logic           misalign_c;
    logic           illegal_c;

    store_align u_align (
        .addr_lo_i    (st_addr_i[1:0]),
        .data_i       (st_data_i),
        .f3_i         (st_f3_i),
        .be_c_o       (be_c),
        .wdata_c_o    (wdata_c),
        .misalign_c_o (misalign_c),
        .illegal_c_o  (illegal_c)
    );

    // Next-state and next-output decode; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        st_done_d   = 1'b0;
        st_err_d    = 1'b0;
        err_code_d  = ERR_NONE;
        case (state_q)
            S_IDLE: begin
                if (st_valid_i) begin
                    cnt_d = '0;
                    if (illegal_c) begin
                        state_d    = S_ERR;
                        st_err_d   = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                    end else if (misalign_c) begin
                        state_d    = S_ERR;
                        st_err_d   = 1'b1;
                        err_code_d = ERR_MISALIGN;
                    end else begin
                        state_d     = S_ISSUE;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {st_addr_i[AW-1:2], 2'b00};
                        mem_wdata_d = wdata_c;
                        mem_be_d    = be_c;
                    end
                end
            end
            S_ISSUE: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (mem_ack_i) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    mem_be_d  = '0;
                    st_done_d = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    mem_be_d   = '0;
                    st_err_d   = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                mem_be_d  = '0;
            end
        endcase
        st_ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset drops any in-flight store silently.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            st_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            st_done_q   <= 1'b0;
            st_err_q    <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            st_ready_q  <= st_ready_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            st_done_q   <= st_done_d;
            st_err_q    <= st_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign st_ready_o  = st_ready_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign st_done_o   = st_done_q;
    assign st_err_o    = st_err_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_store_unit.sv
// Testbench for store_unit: scoreboard of expected store outcomes checked per scenario.
`timescale 1ns/1ps
module tb_store_unit;

    localparam int unsigned TO = 15;
    localparam int unsigned AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          st_valid_i = 1'b0;
    logic          st_ready_o;
    logic [AW-1:0] st_addr_i = '0;
    logic [31:0]   st_data_i = '0;
    logic [2:0]    st_f3_i = '0;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic          mem_ack_i = 1'b0;
    logic          st_done_o;
    logic          st_err_o;
    logic [1:0]    err_code_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          ok;
        logic [1:0]  code;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          req_cycles;
        int          lat;
    } exp_t;

    typedef struct {
        bit          got;
        bit          done;
        bit          err;
        logic [1:0]  code;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          req_cycles;
        bit          stable;
        int          lat;
        int          viol;
    } obs_t;

    exp_t sb_q[$];

    store_unit #(.TIMEOUT(TO), .AW(AW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .st_valid_i  (st_valid_i),
        .st_ready_o  (st_ready_o),
        .st_addr_i   (st_addr_i),
        .st_data_i   (st_data_i),
        .st_f3_i     (st_f3_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_ack_i   (mem_ack_i),
        .st_done_o   (st_done_o),
        .st_err_o    (st_err_o),
        .err_code_o  (err_code_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference outcome: ack_delay = ISSUE cycle index carrying ack (-1 never, -2 always).
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                   input logic [2:0] f3, input int ack_delay);
        exp_t e;
        int   size;
        int   lo;
        int   ad;
        lo = int'(a[1:0]);
        ad = (ack_delay == -2) ? 0 : ack_delay;
        e.addr = a & 32'hFFFF_FFFC;
        e.be = 4'b0000;
        e.wdata = 32'h0;
        case (f3)
            3'b000:  size = 1;
            3'b001:  size = 2;
            3'b010:  size = 4;
            default: size = 0;
        endcase
        if (size == 0) begin
            e.ok = 0; e.code = 2'b10; e.req_cycles = 0; e.lat = 0;
        end else if ((lo % size) != 0) begin
            e.ok = 0; e.code = 2'b01; e.req_cycles = 0; e.lat = 0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (b >= lo && b < lo + size) e.be[b] = 1'b1;
                e.wdata[8*b +: 8] = d[8*(b % size) +: 8];
            end
            if (ad < 0 || ad >= int'(TO)) begin
                e.ok = 0; e.code = 2'b11; e.req_cycles = TO; e.lat = TO;
            end else begin
                e.ok = 1; e.code = 2'b00; e.req_cycles = ad + 1; e.lat = ad + 1;
            end
        end
        return e;
    endfunction

    // Present one request and let it be accepted; scrambles st_* afterwards.
    task automatic issue_store(input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f3, input int ack_delay);
        int w;
        w = 0;
        while (st_ready_o !== 1'b1 && w < 20) begin
            @(negedge clk_i);
            w++;
        end
        total++;
        if (st_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL ready_before_issue: got %b want 1", st_ready_o);
        end
        sb_q.push_back(model(a, d, f3, ack_delay));
        st_valid_i = 1'b1;
        st_addr_i  = a;
        st_data_i  = d;
        st_f3_i    = f3;
        @(posedge clk_i);
        #1;
        st_valid_i = 1'b0;
        st_addr_i  = ~a;
        st_data_i  = ~d;
        st_f3_i    = 3'b111;
    endtask

    // Drive mem_ack per ack_delay and record what the DUT does until a pulse appears.
    task automatic observe(input int ack_delay, output obs_t o);
        o = '{default: 0};
        o.stable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            mem_ack_i = (ack_delay == -2) || (c == ack_delay);
            @(negedge clk_i);
            if (st_done_o && st_err_o) o.viol++;
            if (!mem_req_o && mem_be_o != 4'b0000) o.viol++;
            if (mem_req_o) begin
                if (o.req_cycles == 0) begin
                    o.addr = mem_addr_o; o.be = mem_be_o; o.wdata = mem_wdata_o;
                end else if (mem_addr_o !== o.addr || mem_be_o !== o.be || mem_wdata_o !== o.wdata) begin
                    o.stable = 1'b0;
                end
                o.req_cycles++;
            end
            if (st_done_o || st_err_o) begin
                o.got = 1'b1; o.done = st_done_o; o.err = st_err_o;
                o.code = err_code_o; o.lat = c;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        total++; if (st_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", st_ready_o); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
        total++; if (mem_be_o !== 4'b0) begin bad++; $display("FAIL rst_be: got %b want 0000", mem_be_o); end
        total++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin bad++; $display("FAIL rst_addr_wdata: got %h/%h want 0/0", mem_addr_o, mem_wdata_o); end
        total++; if (st_done_o !== 1'b0 || st_err_o !== 1'b0 || err_code_o !== 2'b00) begin bad++; $display("FAIL rst_pulses: got done=%b err=%b code=%b want 0 0 00", st_done_o, st_err_o, err_code_o); end
    endtask

    task automatic test_byte();
        obs_t o; exp_t e;
        issue_store(32'h1003, 32'hAABBCCDD, 3'b000, 0);
        observe(0, o);
        e = sb_q.pop_front();
        total++; if (o.done !== 1'b1 || o.err !== 1'b0) begin bad++; $display("FAIL sb_done: got done=%b err=%b want 1 0", o.done, o.err); end
        total++; if (o.addr !== 32'h1000 || o.addr !== e.addr) begin bad++; $display("FAIL sb_addr: got %h want %h", o.addr, e.addr); end
        total++; if (o.be !== 4'b1000 || o.be !== e.be) begin bad++; $display("FAIL sb_be: got %b want %b", o.be, e.be); end
        total++; if (o.wdata !== 32'hDDDDDDDD) begin bad++; $display("FAIL sb_wdata: got %h want DDDDDDDD", o.wdata); end
        total++; if (o.lat !== e.lat) begin bad++; $display("FAIL sb_latency: got %0d want %0d", o.lat, e.lat); end
    endtask

    task automatic test_half();
        obs_t o; exp_t e;
        issue_store(32'h2002, 32'h12345678, 3'b001, 1);
        observe(1, o);
        e = sb_q.pop_front();
        total++; if (o.done !== 1'b1) begin bad++; $display("FAIL sh_done: got %b want 1", o.done); end
        total++; if (o.be !== e.be || o.wdata !== 32'h56785678) begin bad++; $display("FAIL sh_lanes: got be=%b wd=%h want be=%b wd=56785678", o.be, o.wdata, e.be); end
        issue_store(32'h2001, 32'h12345678, 3'b001, -2);
        observe(-2, o);
        e = sb_q.pop_front();
        total++; if (o.err !== 1'b1 || o.done !== 1'b0 || o.code !== e.code) begin bad++; $display("FAIL sh_misalign: got err=%b done=%b code=%b want 1 0 %b", o.err, o.done, o.code, e.code); end
        total++; if (o.req_cycles !== 0) begin bad++; $display("FAIL sh_misalign_req: got %0d req cycles want 0", o.req_cycles); end
    endtask

    task automatic test_word_delay();
        obs_t o; exp_t e;
        issue_store(32'h3000, 32'hCAFEF00D, 3'b010, 5);
        observe(5, o);
        e = sb_q.pop_front();
        total++; if (o.req_cycles !== 6 || o.req_cycles !== e.req_cycles) begin bad++; $display("FAIL sw_req_cycles: got %0d want %0d", o.req_cycles, e.req_cycles); end
        total++; if (o.stable !== 1'b1) begin bad++; $display("FAIL sw_stable: got %b want 1", o.stable); end
        total++; if (o.be !== 4'b1111 || o.wdata !== 32'hCAFEF00D || o.addr !== 32'h3000) begin bad++; $display("FAIL sw_fields: got %h/%b/%h want 3000/1111/CAFEF00D", o.addr, o.be, o.wdata); end
        total++; if (o.done !== 1'b1 || o.lat !== e.lat) begin bad++; $display("FAIL sw_done: got done=%b lat=%0d want 1 lat=%0d", o.done, o.lat, e.lat); end
        @(negedge clk_i);
        total++; if (st_done_o !== 1'b0) begin bad++; $display("FAIL sw_single_done: got %b want 0", st_done_o); end
    endtask

    task automatic test_illegal_timeout();
        obs_t o; exp_t e;
        issue_store(32'h3001, 32'h0, 3'b011, -2);
        observe(-2, o);
        e = sb_q.pop_front();
        total++; if (o.err !== 1'b1 || o.code !== 2'b10 || o.code !== e.code) begin bad++; $display("FAIL illegal_code: got err=%b code=%b want 1 %b", o.err, o.code, e.code); end
        total++; if (o.req_cycles !== 0 || o.lat !== 0) begin bad++; $display("FAIL illegal_req: got req=%0d lat=%0d want 0 0", o.req_cycles, o.lat); end
        issue_store(32'h3004, 32'h01020304, 3'b010, -1);
        observe(-1, o);
        e = sb_q.pop_front();
        total++; if (o.got !== 1'b1) begin bad++; $display("FAIL timeout_wait: got no pulse want st_err"); end
        total++; if (o.err !== 1'b1 || o.done !== 1'b0 || o.code !== e.code) begin bad++; $display("FAIL timeout_code: got err=%b done=%b code=%b want 1 0 %b", o.err, o.done, o.code, e.code); end
        total++; if (o.req_cycles !== e.req_cycles || o.lat !== e.lat) begin bad++; $display("FAIL timeout_len: got req=%0d lat=%0d want %0d %0d", o.req_cycles, o.lat, e.req_cycles, e.lat); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL timeout_req_low: got %b want 0", mem_req_o); end
        issue_store(32'h3008, 32'h55AA55AA, 3'b010, TO - 1);
        observe(TO - 1, o);
        e = sb_q.pop_front();
        total++; if (o.done !== 1'b1 || o.err !== 1'b0 || o.lat !== e.lat) begin bad++; $display("FAIL ack_at_limit: got done=%b err=%b lat=%0d want 1 0 %0d", o.done, o.err, o.lat, e.lat); end
    endtask

    task automatic test_reset_mid_issue();
        obs_t o; exp_t e; int pulses;
        issue_store(32'h4000, 32'h11223344, 3'b010, -1);
        e = sb_q.pop_back();
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        total++; if (mem_req_o !== 1'b0 || mem_be_o !== 4'b0) begin bad++; $display("FAIL rst_async_req: got req=%b be=%b want 0 0000", mem_req_o, mem_be_o); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (st_done_o || st_err_o) pulses++;
        end
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (st_done_o || st_err_o || mem_req_o) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rst_no_pulse: got %0d pulses want 0", pulses); end
        issue_store(32'h5004, 32'h89ABCDEF, 3'b010, 2);
        observe(2, o);
        e = sb_q.pop_front();
        total++; if (o.done !== 1'b1 || o.addr !== e.addr || o.wdata !== e.wdata || o.lat !== e.lat) begin bad++; $display("FAIL post_rst_sw: got done=%b %h %h lat=%0d want 1 %h %h %0d", o.done, o.addr, o.wdata, o.lat, e.addr, e.wdata, e.lat); end
    endtask

    task automatic test_random();
        obs_t o; exp_t e; logic [31:0] a, d; logic [2:0] f3; int ad;
        for (int i = 0; i < 12; i++) begin
            a  = $urandom;
            d  = $urandom;
            f3 = 3'($urandom_range(0, 4));
            ad = $urandom_range(0, 4);
            issue_store(a, d, f3, ad);
            observe(ad, o);
            e = sb_q.pop_front();
            total++;
            if (o.got !== 1'b1 || o.done !== e.ok || o.err === e.ok || o.code !== e.code || o.lat !== e.lat) begin
                bad++;
                $display("FAIL rnd_result[%0d]: got done=%b err=%b code=%b lat=%0d want ok=%b code=%b lat=%0d", i, o.done, o.err, o.code, o.lat, e.ok, e.code, e.lat);
            end
            total++;
            if (o.req_cycles !== e.req_cycles || (e.req_cycles > 0 && (o.addr !== e.addr || o.be !== e.be || o.wdata !== e.wdata))) begin
                bad++;
                $display("FAIL rnd_mem[%0d]: got req=%0d %h/%b/%h want req=%0d %h/%b/%h", i, o.req_cycles, o.addr, o.be, o.wdata, e.req_cycles, e.addr, e.be, e.wdata);
            end
            total++;
            if (o.viol !== 0 || o.stable !== 1'b1) begin
                bad++;
                $display("FAIL rnd_invariant[%0d]: got viol=%0d stable=%b want 0 1", i, o.viol, o.stable);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_half();
        test_word_delay();
        test_illegal_timeout();
        test_reset_mid_issue();
        test_random();
        total++;
        if (sb_q.size() !== 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
